// File: rtl/line_serializer.sv
// line_serializer
//   Takes whole packed lines over a valid/ready handshake and streams them out
//   one pixel per cycle, tracking x/y position and flagging start/end of line.
//   A sticky done rises after the last pixel of the last line of a frame.
//   The next line is taken on the same edge the current line's last pixel
//   leaves, so consecutive lines stream without a bubble.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   line_in     packed line, pixel 0 in the top PIXEL_W bits
//   line_valid  line_in valid
//   line_ready  a line can be accepted this cycle
//   pix_out     current pixel
//   pix_valid   pix_out valid
//   pix_ready   downstream accepts the pixel
//   pix_x       column of pix_out
//   pix_y       row of pix_out
//   sol         pix_out is column 0
//   eol         pix_out is the last column
//   done        frame fully emitted, held until rst
//
// state    | meaning
// ---------+------------------------------------------
// ST_IDLE  | line buffer empty, waiting for a line
// ST_SHIFT | line buffer loaded, emitting pixels
// ST_DONE  | whole frame emitted, waiting for reset

module line_serializer #(
    parameter int PIXELS_PER_LINE = 30,
    parameter int PIXEL_W         = 24,
    parameter int LINES           = 20,
    parameter int LINE_W          = PIXELS_PER_LINE * PIXEL_W,
    parameter int XW              = $clog2(PIXELS_PER_LINE),
    parameter int YW              = $clog2(LINES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LINE_W-1:0] line_in,
    input  logic              line_valid,
    output logic              line_ready,
    output logic [PIXEL_W-1:0] pix_out,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [XW-1:0]     pix_x,
    output logic [YW-1:0]     pix_y,
    output logic              sol,
    output logic              eol,
    output logic              done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [XW-1:0] X_LAST = XW'(PIXELS_PER_LINE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(LINES - 1);

    logic [1:0]        state;
    logic [LINE_W-1:0] line_buf;
    logic              at_last_x;
    logic              at_last_y;
    logic              pix_xfer;
    logic              line_xfer;

    assign at_last_x = (pix_x == X_LAST);
    assign at_last_y = (pix_y == Y_LAST);

    assign pix_valid = (state == ST_SHIFT);
    assign pix_xfer  = pix_valid && pix_ready;

    // Accepting while the last pixel leaves is what removes the gap between
    // lines; it must look at pix_ready combinationally to do so.
    assign line_ready = (state == ST_IDLE) || (pix_xfer && at_last_x && !at_last_y);
    assign line_xfer  = line_valid && line_ready;

    // The buffer shifts toward the MSB, so the current pixel is always on top.
    assign pix_out = line_buf[LINE_W-1 -: PIXEL_W];

    assign sol = pix_valid && (pix_x == '0);
    assign eol = pix_valid && at_last_x;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            line_buf <= '0;
            pix_x    <= '0;
            pix_y    <= '0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (line_xfer) begin
                        line_buf <= line_in;
                        pix_x    <= '0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (pix_xfer) begin
                        if (!at_last_x) begin
                            line_buf <= {line_buf[LINE_W-PIXEL_W-1:0], {PIXEL_W{1'b0}}};
                            pix_x    <= pix_x + 1'b1;
                        end else if (at_last_y) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            pix_y <= pix_y + 1'b1;
                            pix_x <= '0;
                            if (line_xfer) begin
                                line_buf <= line_in;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_serializer.sv
// tb_line_serializer
//   Directed bench for line_serializer. A small queue model holds the pixels
//   of the line currently expected in the DUT buffer, plus the expected x/y,
//   line_ready and done; every cycle the DUT outputs are compared against it.

module tb_line_serializer;

    localparam int PPL    = 30;
    localparam int PW     = 24;
    localparam int NLINES = 20;
    localparam int LW     = PPL * PW;
    localparam int XW     = $clog2(PPL);
    localparam int YW     = $clog2(NLINES);

    logic          clk = 1'b0;
    logic          rst;
    logic [LW-1:0] line_in;
    logic          line_valid;
    logic          line_ready;
    logic [PW-1:0] pix_out;
    logic          pix_valid;
    logic          pix_ready;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          sol;
    logic          eol;
    logic          done;

    line_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .line_in    (line_in),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .pix_out    (pix_out),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .sol        (sol),
        .eol        (eol),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    logic [PW-1:0] q[$];
    int            exp_x    = 0;
    int            exp_y    = 0;
    bit            exp_done = 1'b0;
    int            line_id  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // pixel i of line id: 010101*i, with id added into the top byte
    function automatic logic [PW-1:0] mk_pix(input int id, input int i);
        logic [PW-1:0] p;
        p = PW'(32'h010101 * i) + PW'(id * 32'h10000);
        return p;
    endfunction

    function automatic logic [LW-1:0] mk_line(input int id);
        logic [LW-1:0] l;
        for (int i = 0; i < PPL; i++) l[LW-1-i*PW -: PW] = mk_pix(id, i);
        return l;
    endfunction

    function automatic logic [LW-1:0] junk_line();
        logic [LW-1:0] l;
        for (int i = 0; i < PPL; i++) l[i*PW +: PW] = PW'($urandom);
        return l;
    endfunction

    // Asserts reset off the clock edge and checks outputs before any edge.
    task automatic apply_reset();
        line_valid = 1'b0;
        pix_ready  = 1'b0;
        line_in    = '0;
        rst        = 1'b1;
        #1;
        chk("rst_line_ready", 32'(line_ready), 32'd1);
        chk("rst_pix_valid",  32'(pix_valid),  32'd0);
        chk("rst_pix_out",    32'(pix_out),    32'd0);
        chk("rst_sol",        32'(sol),        32'd0);
        chk("rst_eol",        32'(eol),        32'd0);
        chk("rst_done",       32'(done),       32'd0);
        chk("rst_pix_x",      32'(pix_x),      32'd0);
        chk("rst_pix_y",      32'(pix_y),      32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        exp_x    = 0;
        exp_y    = 0;
        exp_done = 1'b0;
    endtask

    // Offers nlines lines (line_valid held high while any remain) and checks
    // every output each cycle. line_in carries junk whenever the model says
    // the DUT must not accept. Stops early once stop_px pixels have left.
    task automatic stream(input int nlines, input bit rnd, input int stop_px);
        int sent   = 0;
        int popped = 0;
        int cyc    = 0;
        bit exp_rdy, lv_acc, px_acc, has_pix;
        while (1) begin
            if (sent == nlines && q.size() == 0) break;
            if (stop_px >= 0 && popped == stop_px) break;
            if (cyc >= 4000) begin
                chk("stream_timeout", 32'(cyc), 32'd0);
                break;
            end
            has_pix    = (q.size() != 0);
            pix_ready  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            exp_rdy    = !exp_done && (!has_pix ||
                         (q.size() == 1 && exp_y != NLINES - 1 && pix_ready));
            line_valid = (sent < nlines);
            line_in    = exp_rdy ? mk_line(line_id) : junk_line();
            #1;
            chk("pix_valid",  32'(pix_valid),  32'(has_pix));
            chk("line_ready", 32'(line_ready), 32'(exp_rdy));
            chk("done",       32'(done),       32'(exp_done));
            chk("sol",        32'(sol),        32'(has_pix && exp_x == 0));
            chk("eol",        32'(eol),        32'(has_pix && exp_x == PPL - 1));
            chk("pix_y",      32'(pix_y),      32'(exp_y));
            if (has_pix) begin
                chk("pix_out", 32'(pix_out), 32'(q[0]));
                chk("pix_x",   32'(pix_x),   32'(exp_x));
            end
            lv_acc = line_valid && exp_rdy;
            px_acc = has_pix && pix_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (px_acc) begin
                void'(q.pop_front());
                popped++;
                if (exp_x == PPL - 1) begin
                    if (exp_y == NLINES - 1) exp_done = 1'b1;
                    else begin
                        exp_y++;
                        exp_x = 0;
                    end
                end else begin
                    exp_x++;
                end
            end
            if (lv_acc) begin
                for (int i = 0; i < PPL; i++) q.push_back(mk_pix(line_id, i));
                line_id++;
                sent++;
            end
        end
        line_valid = 1'b0;
    endtask

    initial begin
        line_valid = 1'b0;
        pix_ready  = 1'b0;
        line_in    = '0;
        rst        = 1'b0;

        // power-on reset
        apply_reset();

        // single line, ready high: 000000 .. 1d1d1d, then back to idle
        stream(1, 1'b0, -1);
        #1;
        chk("idle_pix_valid",  32'(pix_valid),  32'd0);
        chk("idle_line_ready", 32'(line_ready), 32'd1);
        chk("idle_pix_y",      32'(pix_y),      32'd1);
        @(posedge clk);
        #1;

        // two lines back-to-back, continuous ready (rows 1,2)
        stream(2, 1'b0, -1);

        // two lines with random stalls (rows 3,4)
        stream(2, 1'b1, -1);

        // reset mid-frame at pixel 12 of row 3
        apply_reset();
        stream(4, 1'b0, 3 * PPL + 12);
        pix_ready = 1'b0;
        #1;
        chk("pre_rst_pix_x", 32'(pix_x), 32'd12);
        chk("pre_rst_pix_y", 32'(pix_y), 32'd3);
        #1;
        apply_reset();
        stream(1, 1'b0, -1);

        // full frame with continuous ready, then line offers in DONE
        apply_reset();
        stream(NLINES, 1'b0, -1);
        chk("frame_done", 32'(done), 32'd1);
        for (int c = 0; c < 3; c++) begin
            line_valid = 1'b1;
            pix_ready  = 1'b1;
            line_in    = junk_line();
            #1;
            chk("done_line_ready", 32'(line_ready), 32'd0);
            chk("done_pix_valid",  32'(pix_valid),  32'd0);
            chk("done_sticky",     32'(done),       32'd1);
            chk("done_pix_y",      32'(pix_y),      32'(NLINES - 1));
            @(posedge clk);
            #1;
        end
        line_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/line_serializer.md
# line_serializer

Output-side counterpart of the grayscale line converter: accepts whole converted lines (PIXELS_PER_LINE packed 24-bit pixels) over a valid/ready handshake and emits them as a pixel stream, one pixel per cycle, to the frame writer. It tracks pixel x/y position, flags start/end of line, and raises a sticky `done` after the last pixel of the last line of a frame. Holds one line buffer and accepts the next line on the cycle the current line's last pixel leaves, so there are no bubbles between lines.

## Interface

- `PIXELS_PER_LINE`, 30, pixels per input line
- `PIXEL_W`, 24, bits per pixel (RGB888 or replicated gray)
- `LINES`, 20, lines per frame
- Derived: `LINE_W = PIXELS_PER_LINE*PIXEL_W` (720); `XW = $clog2(PIXELS_PER_LINE)`; `YW = $clog2(LINES)`

- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `line_in`  in  LINE_W  packed line; pixel 0 in `[LINE_W-1 -: PIXEL_W]`, pixel N-1 in `[PIXEL_W-1:0]`
- `line_valid`  in  1  `line_in` valid
- `line_ready`  out  1  block can accept a line this cycle
- `pix_out`  out  PIXEL_W  current pixel
- `pix_valid`  out  1  `pix_out` valid
- `pix_ready`  in  1  downstream accepts pixel
- `pix_x`  out  XW  column of `pix_out`
- `pix_y`  out  YW  row of `pix_out`
- `sol`  out  1  `pix_out` is column 0 (qualified by `pix_valid`)
- `eol`  out  1  `pix_out` is column PIXELS_PER_LINE-1
- `done`  out  1  frame fully emitted; sticky until `rst`

## Operation

- States: IDLE (buffer empty), SHIFT (buffer holds line, emitting), DONE (frame complete).
- Line transfer: `line_valid && line_ready` at a rising edge. Pixel transfer: `pix_valid && pix_ready`.
- IDLE: `line_ready=1`, `pix_valid=0`. On line transfer: load buffer, `pix_x<=0`, go SHIFT.
- SHIFT: `pix_valid=1`, `pix_out` = buffer top pixel. On pixel transfer with `pix_x < PIXELS_PER_LINE-1`: shift buffer left by PIXEL_W, `pix_x++`.
- Last pixel (`pix_x == PIXELS_PER_LINE-1`) transferred:
  - if `pix_y == LINES-1`: go DONE, `done<=1`.
  - else `pix_y++`, `pix_x<=0`; if a line transfers in the same cycle, load it and stay SHIFT; otherwise go IDLE.
- `line_ready` = IDLE, or (SHIFT && last pixel && `pix_ready` && `pix_y != LINES-1`). It is combinational on `pix_ready`; `line_in` is sampled only on a line transfer.
- `pix_valid` deasserted, or `pix_ready` low: buffer, `pix_x`, `pix_y`, and `pix_out` hold. `pix_out` stays stable while `pix_valid && !pix_ready`.
- DONE: `line_ready=0`, `pix_valid=0`, `done=1`; `line_valid` is ignored. Only `rst` leaves DONE.
- `sol = pix_valid && pix_x==0`; `eol = pix_valid && pix_x==PIXELS_PER_LINE-1`.
- Counters never wrap: `pix_x` max PIXELS_PER_LINE-1, `pix_y` max LINES-1.

## Timing

- Reset (async assert, released synchronously by the environment):
  - state IDLE; buffer, `pix_x`, `pix_y` = 0
  - outputs: `line_ready=1`, `pix_valid=0`, `pix_out=0`, `sol=0`, `eol=0`, `done=0`
- Reset mid-line or mid-frame: buffered pixels are discarded and the frame restarts at row 0.
- Latency: line accepted at edge k gives pixel 0 valid after edge k (cycle k+1).
- Throughput: with `pix_ready` held high and lines offered back-to-back, one pixel per cycle. The pixel at column N-1 of row r is followed directly by column 0 of row r+1, with no gap.
- Full frame with continuous ready: first line accepted at edge 0, last pixel transferred at edge `PIXELS_PER_LINE*LINES`, `done` high after that edge.
- Simultaneous last-pixel transfer and line offer: both complete in the same edge.

## Test plan

- Reset then line `{pixel i = 24'h010101*i}`, `pix_ready=1` -> `pix_valid` rises the cycle after accept; `pix_out` sequence 000000, 010101, …, 1d1d1d; `sol` on first, `eol` on 30th; then IDLE with `line_ready=1`.
- Two lines back-to-back, continuous ready -> 60 consecutive valid cycles; `pix_y` steps 0→1 exactly when `pix_x` wraps 29→0; second `line_ready` pulse coincides with first line's `eol` transfer.
- `pix_ready` toggled pseudo-randomly -> `pix_out`/`pix_x` stable while stalled; the output stream exactly matches the packed input order, with no drops or duplicates.
- Full frame of 20 lines, continuous ready -> `done` rises after edge 600 and stays high; a further `line_valid=1` in DONE is not accepted (`line_ready=0`, `pix_valid=0`).
- Assert `rst` at pixel 12 of row 3 -> all outputs at reset values immediately, without waiting for a clock edge; the next frame starts at `pix_y=0`, `pix_x=0`.
- `line_valid` high while in SHIFT mid-line -> not accepted; `line_in` change has no effect on `pix_out`.
